fc_relu_collector: RTL and testbench

- Downstream stage of the fully connected layer.
- The FC layer streams one input per cycle into its OUTPUT_NODES float processing elements. This block waits a fixed settle time after reset release, then snapshots the layer's parallel output vector into an internal buffer.
- During the snapshot it applies a float ReLU (optional, see below).
- It then serialises the buffered values, one node per transfer, over a valid/ready stream to the next layer or to a host.

---
 rtl/fc_relu_collector_pkg.sv | 22 ++
 rtl/fc_relu_collector_relu.sv | 23 ++
 rtl/fc_relu_collector.sv | 103 ++++++++++
 tb/tb_fc_relu_collector.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fc_relu_collector_pkg.sv
// Shared definitions for the FC-layer output collector.
//   state_t     : collector FSM states (wait for settle, stream, done)
//   FP_*        : IEEE-754 single-precision field constants
//   fp_relu()   : float ReLU on a single-precision word (sign test only)
package fc_relu_collector_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int              FP_W        = 32;
  localparam int              FP_SIGN_BIT = FP_W - 1;
  localparam logic [FP_W-1:0] FP_ZERO     = '0;

  // Any sign-set word (negatives, -0.0, sign-set NaN) becomes +0.0.
  function automatic logic [FP_W-1:0] fp_relu(input logic [FP_W-1:0] v);
    return v[FP_SIGN_BIT] ? FP_ZERO : v;
  endfunction

endpackage

// File: rtl/fc_relu_collector_relu.sv
// fp_relu_unit: combinational float ReLU for one DATA_WIDTH lane.
// Build option: FC_COLLECT_RELU_EN defined -> sign-set words forced to zero;
//               undefined -> word passes through unchanged.
// Ports:
//   i_val  in  DATA_WIDTH  raw node value
//   o_val  out DATA_WIDTH  activated node value
module fp_relu_unit
  import fc_relu_collector_pkg::*;
#(
  parameter int DATA_WIDTH = FP_W
) (
  input  logic [DATA_WIDTH-1:0] i_val,
  output logic [DATA_WIDTH-1:0] o_val
);

`ifdef FC_COLLECT_RELU_EN
  // Sign test only; +NaN and +Inf pass untouched.
  assign o_val = i_val[DATA_WIDTH-1] ? '0 : i_val;
`else
  assign o_val = i_val;
`endif

endmodule

// File: rtl/fc_relu_collector.sv
// fc_relu_collector: waits SETTLE_CYCLES edges after reset release, snapshots
// the FC layer's parallel output vector (through an optional float ReLU) and
// streams it one node per valid/ready transfer.
// Build option: FC_COLLECT_RELU_EN (see fp_relu_unit).
// Ports:
//   clk        in  1                       clock, rising edge
//   reset      in  1                       async, active-high
//   output_fc  in  DATA_WIDTH*OUTPUT_NODES node i at [DATA_WIDTH*i +: DATA_WIDTH]
//   out_data   out DATA_WIDTH              current streamed node value
//   out_idx    out IDX_W                   node index of out_data
//   out_valid  out 1                       stream word valid
//   out_ready  in  1                       downstream accepts the word
//   out_last   out 1                       word is node OUTPUT_NODES-1
//   busy       out 1                       in WAIT or STREAM
//   done       out 1                       in DONE
module fc_relu_collector
  import fc_relu_collector_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int INPUT_NODES   = 100,
  parameter int OUTPUT_NODES  = 32,
  parameter int PE_LATENCY    = 2,
  parameter int SETTLE_CYCLES = INPUT_NODES + PE_LATENCY + 1,
  localparam int IDX_W = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_fc,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [IDX_W-1:0]                   out_idx,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  state_t                                 r_state, w_state_nxt;
  logic [CNT_W-1:0]                       r_cnt;
  logic [IDX_W-1:0]                       r_idx;
  logic [OUTPUT_NODES-1:0][DATA_WIDTH-1:0] r_buf;
  logic [OUTPUT_NODES-1:0][DATA_WIDTH-1:0] w_raw, w_act;
  logic                                   w_capture, w_xfer, w_last;

  assign w_raw = output_fc;

  for (genvar g = 0; g < OUTPUT_NODES; g++) begin : g_lane
    fp_relu_unit #(.DATA_WIDTH(DATA_WIDTH)) u_relu (
      .i_val (w_raw[g]),
      .o_val (w_act[g])
    );
  end

  // Counter holds edges seen so far; capture on the SETTLE_CYCLES-th edge.
  assign w_capture = (r_state == ST_WAIT) && (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_last    = (r_idx == IDX_W'(OUTPUT_NODES - 1));
  assign w_xfer    = (r_state == ST_STREAM) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_WAIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT:   if (w_capture)          w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_xfer && w_last)   w_state_nxt = ST_DONE;
      ST_DONE:                           w_state_nxt = ST_DONE;
      default:                           w_state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_buf <= '0;
    end else begin
      if (r_state == ST_WAIT && r_cnt != CNT_W'(SETTLE_CYCLES))
        r_cnt <= r_cnt + 1'b1;
      // Buffer is written only here, so later output_fc changes are ignored.
      if (w_capture) begin
        r_buf <= w_act;
        r_idx <= '0;
      end
      // Index stays on the last node after the final transfer.
      if (w_xfer && !w_last)
        r_idx <= r_idx + 1'b1;
    end
  end

  // Outputs come straight from registered state, so they hold under backpressure.
  assign out_valid = (r_state == ST_STREAM);
  assign out_idx   = r_idx;
  assign out_data  = r_buf[r_idx];
  assign out_last  = out_valid && w_last;
  assign busy      = (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_fc_relu_collector.sv
// Directed bench for fc_relu_collector: a 3-node instance (SETTLE_CYCLES=7)
// and a 1-node instance. Expected words depend on FC_COLLECT_RELU_EN.
module tb_fc_relu_collector;

  localparam logic [31:0] N0 = 32'h3F800000;
  localparam logic [31:0] N1 = 32'hC0000000;
  localparam logic [31:0] N2 = 32'h80000000;
  localparam logic [31:0] NA = 32'h40400000;
  localparam logic [31:0] S0 = 32'h41200000;
`ifdef FC_COLLECT_RELU_EN
  localparam logic [31:0] E1 = 32'h0;
  localparam logic [31:0] E2 = 32'h0;
`else
  localparam logic [31:0] E1 = N1;
  localparam logic [31:0] E2 = N2;
`endif

  // Observation vector: {valid, last, busy, done, idx, data}
  localparam logic [37:0] V_IDLE = {4'b0010, 2'd0, 32'h0};
  localparam logic [37:0] V_W0   = {4'b1010, 2'd0, N0};
  localparam logic [37:0] V_W1   = {4'b1010, 2'd1, E1};
  localparam logic [37:0] V_W2   = {4'b1110, 2'd2, E2};
  localparam logic [37:0] V_DONE = {4'b0001, 2'd2, E2};
  localparam logic [36:0] S_IDLE = {4'b0010, 1'b0, 32'h0};
  localparam logic [36:0] S_W0   = {4'b1110, 1'b0, S0};
  localparam logic [36:0] S_DONE = {4'b0001, 1'b0, S0};

  logic        clk = 1'b0;
  logic        reset = 1'b1, rst1 = 1'b1;
  logic [95:0] output_fc;
  logic [31:0] out_data, out_data1;
  logic [1:0]  out_idx;
  logic [0:0]  out_idx1;
  logic        out_valid, out_ready, out_last, busy, done;
  logic        out_valid1, out_ready1, out_last1, busy1, done1;
  logic [37:0] obs;
  logic [36:0] obs1;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign obs  = {out_valid, out_last, busy, done, out_idx, out_data};
  assign obs1 = {out_valid1, out_last1, busy1, done1, out_idx1, out_data1};

  fc_relu_collector #(
    .DATA_WIDTH(32), .INPUT_NODES(4), .OUTPUT_NODES(3), .PE_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .output_fc(output_fc),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  fc_relu_collector #(
    .DATA_WIDTH(32), .INPUT_NODES(4), .OUTPUT_NODES(1), .PE_LATENCY(2)
  ) dut1 (
    .clk(clk), .reset(rst1), .output_fc(S0),
    .out_data(out_data1), .out_idx(out_idx1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_last(out_last1), .busy(busy1), .done(done1)
  );

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves reset released at a falling edge; the next rising edge is edge 1.
  task automatic restart();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL reset3: got %h want %h", obs, V_IDLE); end
    checks++; if (obs1 !== S_IDLE) begin errors++; $display("FAIL reset1: got %h want %h", obs1, S_IDLE); end
  endtask

  task automatic test_stream();
    restart();
    for (int k = 1; k <= 6; k++) begin
      edges(1);
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL wait_e%0d: got %h want %h", k, obs, V_IDLE); end
    end
    edges(1);
    checks++; if (obs !== V_W0) begin errors++; $display("FAIL stream_e7: got %h want %h", obs, V_W0); end
    edges(1);
    checks++; if (obs !== V_W1) begin errors++; $display("FAIL stream_e8: got %h want %h", obs, V_W1); end
    edges(1);
    checks++; if (obs !== V_W2) begin errors++; $display("FAIL stream_e9: got %h want %h", obs, V_W2); end
    edges(1);
    checks++; if (obs !== V_DONE) begin errors++; $display("FAIL done_e10: got %h want %h", obs, V_DONE); end
    edges(3);
    checks++; if (obs !== V_DONE) begin errors++; $display("FAIL done_hold: got %h want %h", obs, V_DONE); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    restart();
    edges(6);
    checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL bp_wait: got %h want %h", obs, V_IDLE); end
    for (int k = 7; k <= 10; k++) begin
      edges(1);
      checks++; if (obs !== V_W0) begin errors++; $display("FAIL bp_hold_e%0d: got %h want %h", k, obs, V_W0); end
    end
    out_ready = 1'b1;
    // Word 0 transfers on edge 11, word 1 on 12, word 2 on 13.
    edges(1);
    checks++; if (obs !== V_W1) begin errors++; $display("FAIL bp_e11: got %h want %h", obs, V_W1); end
    edges(1);
    checks++; if (obs !== V_W2) begin errors++; $display("FAIL bp_e12: got %h want %h", obs, V_W2); end
    edges(1);
    checks++; if (obs !== V_DONE) begin errors++; $display("FAIL bp_e13: got %h want %h", obs, V_DONE); end
  endtask

  task automatic test_capture_hold();
    restart();
    edges(7);
    checks++; if (obs !== V_W0) begin errors++; $display("FAIL cap_e7: got %h want %h", obs, V_W0); end
    output_fc = {NA, NA, NA};
    edges(1);
    checks++; if (obs !== V_W1) begin errors++; $display("FAIL cap_e8: got %h want %h", obs, V_W1); end
    edges(1);
    checks++; if (obs !== V_W2) begin errors++; $display("FAIL cap_e9: got %h want %h", obs, V_W2); end
    output_fc = {N2, N1, N0};
  endtask

  task automatic test_reset_mid();
    restart();
    edges(8);
    checks++; if (obs !== V_W1) begin errors++; $display("FAIL mid_e8: got %h want %h", obs, V_W1); end
    reset = 1'b1;
    #1;
    checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL mid_async: got %h want %h", obs, V_IDLE); end
    @(negedge clk);
    reset = 1'b0;
    edges(6);
    checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL mid_wait: got %h want %h", obs, V_IDLE); end
    edges(1);
    checks++; if (obs !== V_W0) begin errors++; $display("FAIL mid_restart: got %h want %h", obs, V_W0); end
  endtask

  task automatic test_single();
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    edges(6);
    checks++; if (obs1 !== S_IDLE) begin errors++; $display("FAIL one_wait: got %h want %h", obs1, S_IDLE); end
    edges(1);
    checks++; if (obs1 !== S_W0) begin errors++; $display("FAIL one_e7: got %h want %h", obs1, S_W0); end
    edges(1);
    checks++; if (obs1 !== S_DONE) begin errors++; $display("FAIL one_e8: got %h want %h", obs1, S_DONE); end
  endtask

  initial begin
    output_fc  = {N2, N1, N0};
    out_ready  = 1'b1;
    out_ready1 = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_capture_hold();
    test_reset_mid();
    test_single();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
